// File: rtl/peripheral_gpio_apb4_arbiter.sv
// rtl/peripheral_gpio_apb4_arbiter.sv - round-robin APB4 master arbiter in front of the GPIO slave
module peripheral_gpio_apb4_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int PADDR_SIZE = 8,
    parameter int PDATA_SIZE = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic                           PCLK,
    input  logic                           PRESET,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ*PADDR_SIZE-1:0]  req_addr,
    input  logic [NUM_REQ*PDATA_SIZE-1:0]  req_wdata,
    input  logic [NUM_REQ*PDATA_SIZE/8-1:0] req_strb,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [PDATA_SIZE-1:0]          rsp_rdata,
    output logic                           rsp_err,
    output logic                           PSEL,
    output logic                           PENABLE,
    output logic                           PWRITE,
    output logic [PADDR_SIZE-1:0]          PADDR,
    output logic [PDATA_SIZE-1:0]          PWDATA,
    output logic [PDATA_SIZE/8-1:0]        PSTRB,
    input  logic [PDATA_SIZE-1:0]          PRDATA,
    input  logic                           PREADY,
    input  logic                           PSLVERR
);
    localparam int STRB_W = PDATA_SIZE / 8;
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW     = IDX_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d, idx_q, idx_d, win;
    logic [CW-1:0]           sum;
    logic                    found;
    logic [7:0]              cnt_q, cnt_d;
    logic                    psel_q, psel_d, pen_q, pen_d, pwrite_q, pwrite_d;
    logic [PADDR_SIZE-1:0]   paddr_q, paddr_d;
    logic [PDATA_SIZE-1:0]   pwdata_q, pwdata_d, rdata_q, rdata_d;
    logic [STRB_W-1:0]       pstrb_q, pstrb_d;
    logic                    err_q, err_d;

    // Round-robin search: first valid requester at or after the pointer, wrapping.
    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr_q} + CW'(k);
            if (sum >= CW'(NUM_REQ)) sum = sum - CW'(NUM_REQ);
            if (!found && req_valid[sum[IDX_W-1:0]]) begin
                found = 1'b1;
                win   = sum[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        psel_d    = psel_q;
        pen_d     = pen_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        req_ready = '0;
        rsp_valid = '0;
        case (state_q)
            S_IDLE: begin
                if (found && !PRESET) begin
                    req_ready[win] = 1'b1;
                    idx_d    = win;
                    cnt_d    = '0;
                    psel_d   = 1'b1;
                    pen_d    = 1'b0;
                    pwrite_d = req_write[win];
                    paddr_d  = req_addr[win*PADDR_SIZE +: PADDR_SIZE];
                    pwdata_d = req_wdata[win*PDATA_SIZE +: PDATA_SIZE];
                    pstrb_d  = req_write[win] ? req_strb[win*STRB_W +: STRB_W] : '0;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                pen_d   = 1'b1;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                cnt_d = cnt_q + 8'd1;
                // PREADY takes priority over a timeout expiring in the same cycle.
                if (PREADY || (cnt_q + 8'd1 == 8'(TIMEOUT))) begin
                    rdata_d  = (PREADY && !pwrite_q) ? PRDATA : '0;
                    err_d    = PREADY ? PSLVERR : 1'b1;
                    cnt_d    = '0;
                    psel_d   = 1'b0;
                    pen_d    = 1'b0;
                    pwrite_d = 1'b0;
                    paddr_d  = '0;
                    pwdata_d = '0;
                    pstrb_d  = '0;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid[idx_q] = 1'b1;
                ptr_d   = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            psel_q   <= 1'b0;
            pen_q    <= 1'b0;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            psel_q   <= psel_d;
            pen_q    <= pen_d;
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pstrb_q  <= pstrb_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign PSEL      = psel_q;
    assign PENABLE   = pen_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PSTRB     = pstrb_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
endmodule
